editor_campo_rtc: RTL and testbench

//  Downstream of the write-control FSM (Control_Escribir) in the RTC programming path.

---
 rtl/editor_campo_rtc.sv | 129 ++++++++++++
 tb/tb_editor_campo_rtc.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/editor_campo_rtc.sv
// Editable RTC time/date field: loads a BCD value, steps it with pushbuttons, commits one BCD byte with a write strobe.
// Optional AUTOREPEAT_EN adds hold-to-repeat stepping; the default build steps on rising edges only.
module editor_campo_rtc #(
  parameter logic [15:0] MIN1_MASK  = 16'h0030
`ifdef AUTOREPEAT_EN
  , parameter logic [23:0] REPEAT_DLY = 24'd5_000_000
  , parameter logic [23:0] REPEAT_PER = 24'd1_000_000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Num_Ld,
  input  logic       Wr_reg,
  input  logic [3:0] sel_reg_W,
  input  logic [6:0] Cont_max,
  input  logic       PB_up,
  input  logic       PB_down,
  input  logic [7:0] dato_rd,
  output logic [7:0] dato_W,
  output logic [3:0] dir_W,
  output logic       wr_strobe,
  output logic       editando
);

  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

  state_t     state_q;
  logic [6:0] val_q;
  logic [3:0] dir_q;
  logic       wr_strobe_q;
  logic       editando_q;
  logic       up_q;
  logic       down_q;

  logic [7:0] ld_raw_d;
  logic [6:0] ld_min_d;
  logic [6:0] ld_val_d;
  logic [6:0] cur_min_d;
  logic [6:0] val_inc_d;
  logic [6:0] val_dec_d;
  logic       rep_fire_d;
  logic       step_up_d;
  logic       step_dn_d;

`ifdef AUTOREPEAT_EN
  logic [23:0] hold_q;

  assign rep_fire_d = (state_q == EDIT) && (PB_up ^ PB_down) && (hold_q == REPEAT_DLY - 24'd1);
`else
  assign rep_fire_d = 1'b0;
`endif

  always_comb begin
    ld_raw_d  = {4'h0, dato_rd[7:4]} * 8'd10 + {4'h0, dato_rd[3:0]};
    ld_min_d  = {6'd0, MIN1_MASK[sel_reg_W]};
    // Out-of-range reads (including a smaller Cont_max) fall back to the field minimum.
    ld_val_d  = (ld_raw_d > {1'b0, Cont_max} || ld_raw_d < {1'b0, ld_min_d}) ? ld_min_d : ld_raw_d[6:0];
    cur_min_d = {6'd0, MIN1_MASK[dir_q]};
    val_inc_d = (val_q >= Cont_max) ? cur_min_d : val_q + 7'd1;
    val_dec_d = (val_q <= cur_min_d || val_q > Cont_max) ? Cont_max : val_q - 7'd1;
    step_up_d = (PB_up & ~up_q) | (rep_fire_d & PB_up);
    step_dn_d = (PB_down & ~down_q) | (rep_fire_d & PB_down);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      val_q       <= 7'd0;
      dir_q       <= 4'd0;
      wr_strobe_q <= 1'b0;
      editando_q  <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
`ifdef AUTOREPEAT_EN
      hold_q      <= 24'd0;
`endif
    end else begin
      up_q        <= PB_up;
      down_q      <= PB_down;
      wr_strobe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Num_Ld) begin
            val_q      <= ld_val_d;
            dir_q      <= sel_reg_W;
            state_q    <= EDIT;
            editando_q <= 1'b1;
          end
        end
        EDIT: begin
          if (Num_Ld) begin
            val_q <= ld_val_d;
            dir_q <= sel_reg_W;
          end else if (Wr_reg) begin
            state_q     <= COMMIT;
            wr_strobe_q <= 1'b1;
            editando_q  <= 1'b0;
          end else if (step_up_d && !step_dn_d) begin
            val_q <= val_inc_d;
          end else if (step_dn_d && !step_up_d) begin
            val_q <= val_dec_d;
          end
        end
        COMMIT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          editando_q <= 1'b0;
        end
      endcase
`ifdef AUTOREPEAT_EN
      // Reloading to DLY-PER makes every later repeat land PER cycles after the previous one.
      if (state_q == EDIT && (PB_up ^ PB_down)) begin
        if (hold_q == REPEAT_DLY - 24'd1) hold_q <= REPEAT_DLY - REPEAT_PER;
        else                              hold_q <= hold_q + 24'd1;
      end else begin
        hold_q <= 24'd0;
      end
`endif
    end
  end

  assign dato_W    = {4'(val_q / 7'd10), 4'(val_q % 7'd10)};
  assign dir_W     = dir_q;
  assign wr_strobe = wr_strobe_q;
  assign editando  = editando_q;

endmodule

// File: tb/tb_editor_campo_rtc.sv
// Bench for editor_campo_rtc: directed scenarios then randomized traffic against a behavioural field-editor model.
module tb_editor_campo_rtc;

  logic       clk = 1'b0;
  logic       reset;
  logic       num_ld;
  logic       wr_reg;
  logic [3:0] sel_reg_w;
  logic [6:0] cont_max;
  logic       pb_up;
  logic       pb_down;
  logic [7:0] dato_rd;
  logic [7:0] dato_w;
  logic [3:0] dir_w;
  logic       wr_strobe;
  logic       editando;

  int checks = 0;
  int errors = 0;

  // Model of the field editor: mode 0 idle, 1 editing, 2 committing
  int   m_mode = 0;
  int   m_val  = 0;
  int   m_dir  = 0;
  bit   m_pu   = 0;
  bit   m_pd   = 0;

  always #5 clk = ~clk;

  editor_campo_rtc dut (
    .clk      (clk),
    .reset    (reset),
    .Num_Ld   (num_ld),
    .Wr_reg   (wr_reg),
    .sel_reg_W(sel_reg_w),
    .Cont_max (cont_max),
    .PB_up    (pb_up),
    .PB_down  (pb_down),
    .dato_rd  (dato_rd),
    .dato_W   (dato_w),
    .dir_W    (dir_w),
    .wr_strobe(wr_strobe),
    .editando (editando)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic int field_min(input int code);
    return ((16'h0030 >> code) & 1) != 0 ? 1 : 0;
  endfunction

  task automatic model_load();
    int v;
    int mn;
    v  = int'(dato_rd[7:4]) * 10 + int'(dato_rd[3:0]);
    mn = field_min(int'(sel_reg_w));
    m_val = (v > int'(cont_max) || v < mn) ? mn : v;
    m_dir = int'(sel_reg_w);
  endtask

  task automatic model_step();
    bit up_e, dn_e;
    int mn, cmax;
    up_e = pb_up && !m_pu;
    dn_e = pb_down && !m_pd;
    mn   = field_min(m_dir);
    cmax = int'(cont_max);
    if (reset) begin
      m_mode = 0; m_val = 0; m_dir = 0;
    end else if (m_mode == 0) begin
      if (num_ld) begin model_load(); m_mode = 1; end
    end else if (m_mode == 1) begin
      if (num_ld) model_load();
      else if (wr_reg) m_mode = 2;
      else if (up_e && !dn_e) m_val = (m_val >= cmax) ? mn : m_val + 1;
      else if (dn_e && !up_e) m_val = (m_val <= mn || m_val > cmax) ? cmax : m_val - 1;
    end else begin
      m_mode = 0;
    end
    m_pu = reset ? 1'b0 : pb_up;
    m_pd = reset ? 1'b0 : pb_down;
  endtask

  // Apply inputs at the falling edge, advance one rising edge, compare at the next falling edge.
  task automatic tick(input bit r, input bit ld, input bit wr, input logic [3:0] sel,
                      input logic [6:0] cmax, input bit up, input bit dn, input logic [7:0] rd);
    reset = r; num_ld = ld; wr_reg = wr; sel_reg_w = sel;
    cont_max = cmax; pb_up = up; pb_down = dn; dato_rd = rd;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("dato_W", 32'(dato_w), 32'(to_bcd(m_val)));
    check("dir_W", 32'(dir_w), 32'(m_dir));
    check("wr_strobe", 32'(wr_strobe), 32'(m_mode == 2));
    check("editando", 32'(editando), 32'(m_mode == 1));
  endtask

  initial begin
    logic [6:0] cm_tab [6];
    logic [6:0] cm;
    logic [3:0] sel;
    bit up, dn;
    cm_tab[0] = 7'd59; cm_tab[1] = 7'd23; cm_tab[2] = 7'd12;
    cm_tab[3] = 7'd31; cm_tab[4] = 7'd99; cm_tab[5] = 7'd9;

    reset = 1'b1; num_ld = 1'b0; wr_reg = 1'b0; sel_reg_w = 4'd0;
    cont_max = 7'd59; pb_up = 1'b0; pb_down = 1'b0; dato_rd = 8'h00;
    @(negedge clk);
    tick(1, 0, 0, 4'd0, 7'd59, 0, 0, 8'h00);
    check("reset_dato", 32'(dato_w), 32'h00);
    check("reset_edit", 32'(editando), 32'h0);
    check("reset_strobe", 32'(wr_strobe), 32'h0);

    // Wrap upward at Cont_max for a min-0 field
    tick(0, 1, 0, 4'd0, 7'd59, 0, 0, 8'h58);
    check("t1_load", 32'(dato_w), 32'h58);
    tick(0, 0, 0, 4'd0, 7'd59, 1, 0, 8'h00);
    check("t1_up1", 32'(dato_w), 32'h59);
    tick(0, 0, 0, 4'd0, 7'd59, 0, 0, 8'h00);
    tick(0, 0, 0, 4'd0, 7'd59, 1, 0, 8'h00);
    check("t1_wrap", 32'(dato_w), 32'h00);

    // Min-1 field wraps both ways
    tick(0, 1, 0, 4'd4, 7'd12, 0, 0, 8'h01);
    tick(0, 0, 0, 4'd4, 7'd12, 0, 1, 8'h00);
    check("t2_down", 32'(dato_w), 32'h12);
    tick(0, 0, 0, 4'd4, 7'd12, 0, 0, 8'h00);
    tick(0, 0, 0, 4'd4, 7'd12, 1, 0, 8'h00);
    check("t2_up", 32'(dato_w), 32'h01);

    // Load clamp then commit
    tick(0, 1, 0, 4'd2, 7'd23, 0, 0, 8'h45);
    check("t3_clamp", 32'(dato_w), 32'h00);
    tick(0, 0, 1, 4'd2, 7'd23, 0, 0, 8'h00);
    check("t3_strobe", 32'(wr_strobe), 32'h1);
    check("t3_dir", 32'(dir_w), 32'h2);
    tick(0, 0, 0, 4'd2, 7'd23, 0, 0, 8'h00);
    check("t3_strobe_off", 32'(wr_strobe), 32'h0);

    // Simultaneous edges, and Num_Ld beating Wr_reg
    tick(0, 1, 0, 4'd0, 7'd59, 0, 0, 8'h10);
    tick(0, 0, 0, 4'd0, 7'd59, 1, 1, 8'h00);
    check("t4_both", 32'(dato_w), 32'h10);
    tick(0, 0, 0, 4'd0, 7'd59, 0, 0, 8'h00);
    tick(0, 1, 1, 4'd1, 7'd59, 0, 0, 8'h33);
    check("t4_reload", 32'(dato_w), 32'h33);
    check("t4_nostrobe", 32'(wr_strobe), 32'h0);
    check("t4_editing", 32'(editando), 32'h1);

    // Reset wins over a commit request
    tick(1, 0, 1, 4'd1, 7'd59, 0, 0, 8'h00);
    check("t5_strobe", 32'(wr_strobe), 32'h0);
    check("t5_dato", 32'(dato_w), 32'h00);
    check("t5_edit", 32'(editando), 32'h0);

    cm = 7'd59; sel = 4'd0; up = 0; dn = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) cm = cm_tab[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) up = ~up;
      if ($urandom_range(0, 3) == 0) dn = ~dn;
      sel = 4'($urandom_range(0, 15));
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 14) == 0,
           sel, cm, up, dn, {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
